// File: rtl/pcoeff_result_collector_pkg.sv
// Shared definitions for the pcoeff result collector and the host-side result writer:
// field widths derived from the pack's count width, FSM encoding and the result record layout.
package pcoeff_result_collector_pkg;

    localparam int PCOEFF_COUNT_BITWIDTH = 10;
    localparam int DEF_COUNT_W           = PCOEFF_COUNT_BITWIDTH + 2;
    localparam int DEF_SUM_W             = DEF_COUNT_W + 35;
    localparam int DEF_IDX_W             = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRAB,
        ST_HOLD
    } state_e;

    // Record layout as stored in the FIFO, most significant field first.
    typedef struct packed {
        logic [DEF_IDX_W-1:0]   index;
        logic [DEF_SUM_W-1:0]   sum;
        logic [DEF_COUNT_W-1:0] count;
    } result_t;

    function automatic int result_width(input int idx_w, input int sum_w, input int count_w);
        return idx_w + sum_w + count_w;
    endfunction

endpackage

// File: rtl/pcoeff_result_collector_if.sv
// Pack-side grab handshake plus host-side valid/ready result stream of the collector.
interface pcoeff_result_collector_if
    import pcoeff_result_collector_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int SUM_W   = DEF_SUM_W,
    parameter int IDX_W   = DEF_IDX_W
);
    logic               resultsAvailable;
    logic               grabResults;
    logic [SUM_W-1:0]   pcoeffSum;
    logic [COUNT_W-1:0] pcoeffCount;
    logic               outValid;
    logic               outReady;
    logic [IDX_W-1:0]   outBatchIndex;
    logic [SUM_W-1:0]   outSum;
    logic [COUNT_W-1:0] outCount;

    // The collector drives the grab pulse and the output stream.
    modport master (
        input  resultsAvailable, pcoeffSum, pcoeffCount, outReady,
        output grabResults, outValid, outBatchIndex, outSum, outCount
    );

    modport slave (
        output resultsAvailable, pcoeffSum, pcoeffCount, outReady,
        input  grabResults, outValid, outBatchIndex, outSum, outCount
    );

endinterface

// File: rtl/pcoeff_result_collector_fifo.sv
// Register-based first-word-fall-through FIFO; head data is visible combinationally and
// reads as zero while empty. A write into a full FIFO is accepted only with a same-cycle pop.
module result_fwft_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   used_q, used_d;
    logic                  push;
    logic                  pop;

    assign full    = (used_q == FULL_COUNT);
    assign empty   = (used_q == '0);
    assign used    = used_q;
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   used_d = used_q + (DEPTH_LOG2+1)'(1);
            2'b01:   used_d = used_q - (DEPTH_LOG2+1)'(1);
            default: used_d = used_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pcoeff_result_collector.sv
// Drains per-batch results from the permutation pipeline pack, tags them with a wrapping
// batch index and streams them out through a FWFT FIFO; grabs only issue with guaranteed space.
module pcoeff_result_collector
    import pcoeff_result_collector_pkg::*;
#(
    parameter int COUNT_W      = DEF_COUNT_W,
    parameter int SUM_W        = DEF_SUM_W,
    parameter int READ_LATENCY = 8,
    parameter int HOLDOFF      = 4,
    parameter int DEPTH_LOG2   = 4,
    parameter int IDX_W        = DEF_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    pcoeff_result_collector_if.master   bus,
    output logic [DEPTH_LOG2:0]         inFlight,
    output logic                        overflowError
);
    localparam int REC_W  = result_width(IDX_W, SUM_W, COUNT_W);
    localparam int HOLD_W = $clog2(HOLDOFF);
    localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(HOLDOFF - 2);
    localparam logic [DEPTH_LOG2+1:0]   CAPACITY  = {2'b01, {DEPTH_LOG2{1'b0}}};

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                    grab_q, grab_d;
    logic [DEPTH_LOG2:0]     in_flight_q, in_flight_d;
    logic [READ_LATENCY-1:0] dly_q, dly_d;
    logic [IDX_W-1:0]        batch_q, batch_d;
    logic                    overflow_q, overflow_d;

    logic                    issue;
    logic                    capture;
    logic                    credit;
    logic                    pop;
    logic [REC_W-1:0]        head;
    logic [DEPTH_LOG2:0]     used;
    logic                    full;
    logic                    empty;

    // Outstanding grabs count against space so every in-flight result has a slot reserved.
    assign credit  = ({1'b0, used} + {1'b0, in_flight_q}) < CAPACITY;
    assign capture = dly_q[READ_LATENCY-1];
    assign pop     = !empty && bus.outReady;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.resultsAvailable && credit) begin
                    state_d = ST_GRAB;
                    issue   = 1'b1;
                end
            end
            ST_GRAB: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                // resultsAvailable may still reflect the batch just grabbed, so it is ignored here.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grab_d      = issue;
        dly_d       = {dly_q[READ_LATENCY-2:0], grab_q};
        batch_d     = capture ? batch_q + IDX_W'(1) : batch_q;
        overflow_d  = overflow_q | (capture && full && !pop);
        in_flight_d = in_flight_q;
        case ({issue, capture})
            2'b10:   in_flight_d = in_flight_q + (DEPTH_LOG2+1)'(1);
            2'b01:   in_flight_d = in_flight_q - (DEPTH_LOG2+1)'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            grab_q      <= 1'b0;
            in_flight_q <= '0;
            dly_q       <= '0;
            batch_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            grab_q      <= grab_d;
            in_flight_q <= in_flight_d;
            dly_q       <= dly_d;
            batch_q     <= batch_d;
            overflow_q  <= overflow_d;
        end
    end

    result_fwft_fifo #(
        .WIDTH      (REC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data ({batch_q, bus.pcoeffSum, bus.pcoeffCount}),
        .rd_en   (bus.outReady),
        .rd_data (head),
        .used    (used),
        .full    (full),
        .empty   (empty)
    );

    assign bus.grabResults                             = grab_q;
    assign bus.outValid                                = !empty;
    assign {bus.outBatchIndex, bus.outSum, bus.outCount} = head;
    assign inFlight                                    = in_flight_q;
    assign overflowError                               = overflow_q;

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Directed bench: a pack model answers grabs after READ_LATENCY cycles, a scoreboard queue
// holds the expected tagged results; a second collector with IDX_W=4 shares the stimulus.
module tb_pcoeff_result_collector;
    import pcoeff_result_collector_pkg::*;

    localparam int COUNT_W = 12;
    localparam int SUM_W   = 47;
    localparam int RL      = 8;
    localparam int HOLDOFF = 4;
    localparam int DL2     = 4;
    localparam int IDX_W   = 16;
    localparam int IDX_W_S = 4;

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [SUM_W-1:0]   sum;
        logic [COUNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               results_available;
    logic               out_ready;
    logic [SUM_W-1:0]   pack_sum;
    logic [COUNT_W-1:0] pack_count;
    logic [DL2:0]       in_flight_a, in_flight_b;
    logic               ovf_a, ovf_b;

    pcoeff_result_collector_if #(.COUNT_W(COUNT_W), .SUM_W(SUM_W), .IDX_W(IDX_W))   bus_a ();
    pcoeff_result_collector_if #(.COUNT_W(COUNT_W), .SUM_W(SUM_W), .IDX_W(IDX_W_S)) bus_b ();

    assign bus_a.resultsAvailable = results_available;
    assign bus_a.outReady         = out_ready;
    assign bus_a.pcoeffSum        = pack_sum;
    assign bus_a.pcoeffCount      = pack_count;
    assign bus_b.resultsAvailable = results_available;
    assign bus_b.outReady         = out_ready;
    assign bus_b.pcoeffSum        = pack_sum;
    assign bus_b.pcoeffCount      = pack_count;

    pcoeff_result_collector #(
        .COUNT_W(COUNT_W), .SUM_W(SUM_W), .READ_LATENCY(RL),
        .HOLDOFF(HOLDOFF), .DEPTH_LOG2(DL2), .IDX_W(IDX_W)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .inFlight(in_flight_a), .overflowError(ovf_a)
    );

    pcoeff_result_collector #(
        .COUNT_W(COUNT_W), .SUM_W(SUM_W), .READ_LATENCY(RL),
        .HOLDOFF(HOLDOFF), .DEPTH_LOG2(DL2), .IDX_W(IDX_W_S)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .inFlight(in_flight_b), .overflowError(ovf_b)
    );

    // Standalone FIFO for the full-with-simultaneous-push/pop corner.
    logic       f_wr, f_rd, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    logic [2:0] f_used;

    result_fwft_fifo #(.WIDTH(8), .DEPTH_LOG2(2)) u_fifo (
        .clk(clk), .rst(rst), .wr_en(f_wr), .wr_data(f_din), .rd_en(f_rd),
        .rd_data(f_dout), .used(f_used), .full(f_full), .empty(f_empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] sum_of(input int n);
        if (n == 0) return SUM_W'(48'h1234);
        return {15'(n), 32'(32'hA500_0000 ^ (n * 7919))};
    endfunction

    function automatic logic [COUNT_W-1:0] count_of(input int n);
        if (n == 0) return COUNT_W'(5);
        return COUNT_W'(n * 37 + 1);
    endfunction

    // Pack model: data for the grab seen in cycle c is presented during cycle c+RL.
    logic [RL-1:0] pv = '0;
    int            pseq [RL];
    int            grab_seq = 0;

    always @(posedge clk) begin
        pv       <= {pv[RL-2:0], bus_a.grabResults};
        pseq[0]  <= grab_seq;
        for (int i = 1; i < RL; i++) pseq[i] <= pseq[i-1];
        if (bus_a.grabResults) grab_seq <= grab_seq + 1;
    end

    assign pack_sum   = pv[RL-1] ? sum_of(pseq[RL-1])   : '1;
    assign pack_count = pv[RL-1] ? count_of(pseq[RL-1]) : '1;

    // Scoreboard push on every grab; reset discards everything still pending.
    exp_t exp_q [$];
    int   exp_idx = 0;
    int   cyc = 0;
    int   n_grabs = 0;
    int   last_grab = -1;
    int   min_gap = 1000;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            exp_idx = 0;
        end else if (bus_a.grabResults) begin
            exp_q.push_back('{idx: IDX_W'(exp_idx), sum: sum_of(grab_seq), cnt: count_of(grab_seq)});
            exp_idx++;
            n_grabs++;
            if (last_grab >= 0 && cyc - last_grab < min_gap) min_gap = cyc - last_grab;
            last_grab = cyc;
            check("grab_b_lockstep", 64'(bus_b.grabResults), 64'(1));
        end
    end

    // Output monitor: a handshake visible at the falling edge completes on the next rising edge.
    int   n_pops = 0;
    int   last_idx_a = -1;
    int   last_idx_b = -1;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst && bus_a.outValid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(bus_a.outBatchIndex), 64'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_idx_a",   64'(bus_a.outBatchIndex), 64'(mon_e.idx));
                check("out_sum_a",   64'(bus_a.outSum),        64'(mon_e.sum));
                check("out_count_a", 64'(bus_a.outCount),      64'(mon_e.cnt));
                check("out_valid_b", 64'(bus_b.outValid),      64'(1));
                check("out_idx_b",   64'(bus_b.outBatchIndex), 64'(mon_e.idx[IDX_W_S-1:0]));
                check("out_sum_b",   64'(bus_b.outSum),        64'(mon_e.sum));
                last_idx_a = int'(bus_a.outBatchIndex);
                last_idx_b = int'(bus_b.outBatchIndex);
                n_pops++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick(1);
            if (exp_q.size() == 0 && !bus_a.outValid && in_flight_a == '0 && !bus_a.grabResults) break;
        end
        check({tag, "_drain_in_time"}, 64'(i < budget), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, p0, vcnt;
        logic [7:0] fexp [4];

        rst = 1'b0; results_available = 1'b0; out_ready = 1'b0;
        f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
        tick(3);
        check("rst_grab",      64'(bus_a.grabResults),   64'(0));
        check("rst_valid",     64'(bus_a.outValid),      64'(0));
        check("rst_index",     64'(bus_a.outBatchIndex), 64'(0));
        check("rst_sum",       64'(bus_a.outSum),        64'(0));
        check("rst_count",     64'(bus_a.outCount),      64'(0));
        check("rst_in_flight", 64'(in_flight_a),         64'(0));
        check("rst_overflow",  64'(ovf_a),               64'(0));
        rst = 1'b1;
        tick(2);

        // Single result: exact grab and output latency.
        out_ready = 1'b1;
        results_available = 1'b1;
        tick(1);
        results_available = 1'b0;
        check("single_grab_pulse", 64'(bus_a.grabResults), 64'(1));
        check("single_in_flight",  64'(in_flight_a),       64'(1));
        tick(1);
        check("single_grab_one_cycle", 64'(bus_a.grabResults), 64'(0));
        tick(7);
        check("single_valid_not_early", 64'(bus_a.outValid), 64'(0));
        tick(1);
        check("single_valid_on_time", 64'(bus_a.outValid), 64'(1));
        check("single_sum",   64'(bus_a.outSum),   64'h1234);
        check("single_count", 64'(bus_a.outCount), 64'(5));
        tick(1);
        check("single_in_flight_back", 64'(in_flight_a), 64'(0));
        check("single_popped",         64'(n_pops),      64'(1));
        check("single_grabs",          64'(n_grabs),     64'(1));

        // Stale resultsAvailable held through the holdoff window.
        g0 = n_grabs;
        results_available = 1'b1;
        tick(5);
        results_available = 1'b0;
        tick(3);
        check("stale_one_grab", 64'(n_grabs - g0), 64'(1));
        drain("stale", 40);

        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);

        // Backpressure: credit must stop grabs at exactly the FIFO depth.
        out_ready = 1'b0;
        results_available = 1'b1;
        g0 = n_grabs;
        min_gap = 1000;
        last_grab = -1;
        tick(16 * (HOLDOFF + 1) + RL + 30);
        check("bp_grabs_capped", 64'(n_grabs - g0), 64'(16));
        check("bp_in_flight",    64'(in_flight_a),  64'(0));
        tick(20);
        check("bp_no_more_grabs", 64'(n_grabs - g0),       64'(16));
        check("bp_grab_low",      64'(bus_a.grabResults),  64'(0));
        check("bp_min_gap",       64'(min_gap),            64'(HOLDOFF + 1));
        check("bp_head_valid",    64'(bus_a.outValid),     64'(1));
        check("bp_head_index",    64'(bus_a.outBatchIndex),64'(0));
        p0 = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (n_grabs - g0 >= 17) break;
        end
        results_available = 1'b0;
        check("bp_17th_grab", 64'(n_grabs - g0), 64'(17));
        drain("bp", 80);
        check("bp_all_popped",  64'(n_pops - p0), 64'(17));
        check("wrap_index_a",   64'(last_idx_a),  64'(16));
        check("wrap_index_b",   64'(last_idx_b),  64'(0));
        check("bp_overflow_a",  64'(ovf_a),       64'(0));
        check("bp_overflow_b",  64'(ovf_b),       64'(0));

        // Reset three cycles after a grab: late pack data must be discarded.
        results_available = 1'b1;
        tick(1);
        results_available = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        check("midrst_valid",     64'(bus_a.outValid), 64'(0));
        check("midrst_in_flight", 64'(in_flight_a),    64'(0));
        p0 = n_pops;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (bus_a.outValid) vcnt++;
        end
        check("midrst_no_capture", 64'(vcnt), 64'(0));
        results_available = 1'b1;
        tick(1);
        results_available = 1'b0;
        drain("midrst", 40);
        check("midrst_one_result", 64'(n_pops - p0), 64'(1));
        check("midrst_index_zero", 64'(last_idx_a),  64'(0));

        // Standalone FIFO: fill, push+pop while full, then push while full without pop.
        for (int i = 0; i < 4; i++) begin
            f_wr = 1'b1;
            f_din = 8'(8'h10 + i);
            tick(1);
        end
        f_wr = 1'b0;
        check("fifo_fill_used", 64'(f_used), 64'(4));
        check("fifo_fill_full", 64'(f_full), 64'(1));
        check("fifo_fill_head", 64'(f_dout), 64'h10);
        f_wr = 1'b1; f_din = 8'h20; f_rd = 1'b1;
        tick(1);
        f_wr = 1'b0; f_rd = 1'b0;
        check("fifo_pushpop_used", 64'(f_used), 64'(4));
        check("fifo_pushpop_full", 64'(f_full), 64'(1));
        check("fifo_pushpop_head", 64'(f_dout), 64'h11);
        f_wr = 1'b1; f_din = 8'h30;
        tick(1);
        f_wr = 1'b0;
        check("fifo_drop_used", 64'(f_used), 64'(4));
        fexp = '{8'h11, 8'h12, 8'h13, 8'h20};
        f_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fifo_drain_order", 64'(f_dout), 64'(fexp[i]));
            tick(1);
        end
        f_rd = 1'b0;
        check("fifo_empty",      64'(f_empty), 64'(1));
        check("fifo_empty_data", 64'(f_dout),  64'(0));

        check("final_overflow", 64'(ovf_a), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcoeff_result_collector.md
# pcoeff_result_collector

- Sits directly downstream of the 24-permutation pipeline pack.
- Drains the pack's per-batch results through its `grabResults`/`resultsAvailable` handshake.
- Captures each `pcoeffSum`/`pcoeffCount` pair a fixed latency after the grab and tags it with a wrapping batch index.
- Buffers results in a small first-word-fall-through FIFO and presents them as a valid/ready stream to the host-side result writer.
- Issues a grab only when buffer space is guaranteed, so no result is ever dropped.

## Interface

Parameters:
- `COUNT_W`, 12, width of `pcoeffCount` (PCOEFF_COUNT_BITWIDTH+2).
- `SUM_W`, 47, width of `pcoeffSum` (COUNT_W+35).
- `READ_LATENCY`, 8, cycles from `grabResults` high to result valid on `pcoeffSum`/`pcoeffCount`.
- `HOLDOFF`, 4, minimum cycles between grabs; covers stale `resultsAvailable`. Must be ≥ 2.
- `DEPTH_LOG2`, 4, log2 of output FIFO depth.
- `IDX_W`, 16, batch index width.

Ports:
- `clk`  in  1  single clock; everything is synchronous to it.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `resultsAvailable`  in  1  pack has a finished batch.
- `grabResults`  out  1  one-cycle grab pulse to the pack.
- `pcoeffSum`  in  SUM_W  result sum, valid READ_LATENCY cycles after grab.
- `pcoeffCount`  in  COUNT_W  result count, same timing.
- `outValid`  out  1  FIFO head valid.
- `outReady`  in  1  consumer accepts head.
- `outBatchIndex`  out  IDX_W  batch tag of head.
- `outSum`  out  SUM_W  head sum.
- `outCount`  out  COUNT_W  head count.
- `inFlight`  out  DEPTH_LOG2+1  grabs issued, not yet captured.
- `overflowError`  out  1  sticky; capture attempted into a full FIFO.

## Operation

- **FSM states:** IDLE, GRAB, HOLD.
  - IDLE → GRAB when `resultsAvailable` && credit.
  - Credit: `used + inFlight < 2^DEPTH_LOG2`, where `used` is the FIFO occupancy.
  - GRAB lasts one cycle with `grabResults`=1 and `inFlight` incremented, then → HOLD.
  - HOLD counts HOLDOFF−1 cycles, then → IDLE. `resultsAvailable` is ignored in HOLD.
- **Capture:** a READ_LATENCY-deep shift register tracks each grab pulse. When its output is 1:
  - write {`batchCounter`, `pcoeffSum`, `pcoeffCount`} to the FIFO;
  - increment `batchCounter`, wrapping at 2^IDX_W−1 → 0;
  - decrement `inFlight`.
- **inFlight:** if an issue and a capture fall in the same cycle, `inFlight` is unchanged.
- **Output:** standard valid/ready. A pop occurs when `outValid && outReady`. FIFO outputs are stable while `outValid && !outReady`.
- **Simultaneous write and pop:** always allowed, including when the FIFO is full.
- **Overflow:** a write when full with no pop sets `overflowError`, and the write is dropped. This is unreachable by design; it exists as an assertion hook.
- **Width rules:** inputs are captured verbatim. No arithmetic is done on sum or count.
- **Reset:** asserting `rst` (low) mid-operation:
  - clears FIFO, FSM, `inFlight`, delay line, `batchCounter` and `overflowError`;
  - discards results still in flight. The pack is reset by the same reset in the system.

## Timing

- **Reset values:** `grabResults`=0, `outValid`=0, `outBatchIndex`=0, `outSum`=0, `outCount`=0, `inFlight`=0, `overflowError`=0. FSM=IDLE.
- **Grab issue:**
  - `resultsAvailable` sampled 1 at edge t (with credit) → `grabResults`=1 during cycle t+1.
  - `grabResults` is a registered output.
- **Capture:** the result is sampled at the edge ending cycle t+1+READ_LATENCY.
- **Output:** `outValid` rises in the following cycle (FIFO write is registered; data falls through with no read latency).
- **Pop:** head advances on the edge where `outValid && outReady`.
- **Throughput:** at most one grab per HOLDOFF+1 cycles.

## Structure

- **Shared package/header:** COUNT_W/SUM_W derivation from PCOEFF_COUNT_BITWIDTH, and the result record layout {index, sum, count}. This lets the result writer unpack the record consistently.
- **Sub-module `result_fwft_fifo`:** width/depth-parameterised register-based FWFT FIFO exposing `used`, `full` and `empty`. Reusable elsewhere.
- **Top level:** FSM, credit logic, grab delay line and batch counter.

## Test plan

- **Single result:** `resultsAvailable`=1 for one cycle, sum=0x1234, count=5 presented at t+1+8, `outReady`=1 → one `grabResults` pulse; out {0, 0x1234, 5}; `inFlight` returns to 0.
- **Stale available:** `resultsAvailable` held high 4 cycles after the grab → exactly one grab; the next grab occurs no earlier than 5 cycles after the first.
- **Backpressure:** `outReady`=0, `resultsAvailable` constantly 1 → exactly 16 grabs issued, then `grabResults` stays 0. Release `outReady` → 16 results out in order with indices 0..15; `overflowError`=0.
- **Full with simultaneous push/pop:** FIFO full, `outReady`=1 in the same cycle a capture lands → no overflow; occupancy stays 16.
- **Index wrap:** IDX_W=4, 17 results → indices 0..15, then 0.
- **Reset mid-flight:** drive `rst` low 3 cycles after a grab → after reset `outValid`=0, `inFlight`=0; the late-arriving pack data is not captured; the next batch is tagged 0.
